// File: rtl/stitch_pkg.sv
// Shared types for the accelerator response path of the stitch core.
package stitch_pkg;

    localparam int unsigned AccIdWidth   = 5;
    localparam int unsigned AccDataWidth = 64;
    localparam int unsigned AccNumIds    = 32;

    typedef logic [AccIdWidth-1:0] acc_id_t;

    // One queued FPU response headed for the integer core.
    typedef struct packed {
        acc_id_t                 id;
        logic [AccDataWidth-1:0] data;
        logic                    error;
    } acc_rsp_t;

endpackage

// File: rtl/fifo_v3.sv
// Trimmed fifo_v3: registered storage with optional fall-through, power-of-two depth.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [31:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned AddrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntWidth  = AddrWidth + 1;

    dtype                 mem_q [DEPTH];
    logic [AddrWidth-1:0] rd_ptr_q;
    logic [AddrWidth-1:0] wr_ptr_q;
    logic [CntWidth-1:0]  cnt_q;
    logic                 stored_empty;
    logic                 bypass;
    logic                 do_push;
    logic                 do_pop;

    // A bypassed entry popped in the same cycle is never written to storage.
    assign stored_empty = (cnt_q == '0);
    assign full_o       = (cnt_q == CntWidth'(DEPTH));
    assign bypass       = FALL_THROUGH && stored_empty && push_i;
    assign empty_o      = stored_empty && !bypass;
    assign data_o       = bypass ? data_i : mem_q[rd_ptr_q];
    assign do_pop       = pop_i && !stored_empty;
    assign do_push      = push_i && !full_o && !(bypass && pop_i);

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
            end
            cnt_q <= cnt_q + CntWidth'(do_push) - CntWidth'(do_pop);
        end
    end

    // Storage array; contents are don't-care while unoccupied.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/stitch_acc_responder.sv
// Tracks offloaded instructions that return integer results and queues FPU responses for the core.
module stitch_acc_responder
    import stitch_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 4,
    parameter type         rsp_t     = acc_rsp_t
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    // upstream issue
    input  logic [AccIdWidth-1:0]        iss_qid_i,
    input  logic                         iss_expect_rsp_i,
    input  logic                         iss_qvalid_i,
    output logic                         iss_qready_o,
    // downstream issue toward the FPU subsystem
    output logic                         iss_qvalid_o,
    input  logic                         iss_qready_i,
    // FPU response
    input  logic [AccIdWidth-1:0]        fpu_pid_i,
    input  logic [DataWidth-1:0]         fpu_pdata_i,
    input  logic                         fpu_perror_i,
    input  logic                         fpu_pvalid_i,
    output logic                         fpu_pready_o,
    // response to the integer core
    output logic [AccIdWidth-1:0]        oup_pid_o,
    output logic [DataWidth-1:0]         oup_pdata_o,
    output logic                         oup_perror_o,
    output logic                         oup_pvalid_o,
    input  logic                         oup_pready_i,
    // status
    output logic [$clog2(Depth+1)-1:0]   outstanding_o,
    output logic                         idle_o,
    output logic                         unexpected_rsp_o
);

    localparam int unsigned        CntWidth = $clog2(Depth + 1);
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(Depth);

    logic [AccNumIds-1:0] pend_q;
    logic [AccNumIds-1:0] pend_d;
    logic [CntWidth-1:0]  out_cnt_q;
    logic [CntWidth-1:0]  out_cnt_d;
    logic                 unexpected_q;

    logic stall;
    logic iss_fire;
    logic track;
    logic fpu_fire;
    logic fpu_hit;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    rsp_t fifo_in;
    rsp_t fifo_out;

    // Issue gating: hold back a tracked issue whose id is still pending or when credits run out.
    assign stall        = iss_expect_rsp_i & (pend_q[iss_qid_i] | (out_cnt_q == CntMax));
    assign iss_qvalid_o = iss_qvalid_i & ~stall;
    assign iss_qready_o = iss_qready_i & ~stall;
    assign iss_fire     = iss_qvalid_i & iss_qready_i & ~stall;
    assign track        = iss_fire & iss_expect_rsp_i;

    // FPU side: always accept while space remains, keep only responses that match a pending id.
    assign fpu_pready_o = ~fifo_full;
    assign fpu_fire     = fpu_pvalid_i & ~fifo_full;
    assign fpu_hit      = pend_q[fpu_pid_i];
    assign push         = fpu_fire & fpu_hit;

    // Core side is driven straight from the registered FIFO head.
    assign oup_pvalid_o = ~fifo_empty;
    assign oup_pid_o    = fifo_out.id;
    assign oup_pdata_o  = fifo_out.data;
    assign oup_perror_o = fifo_out.error;
    assign pop          = ~fifo_empty & oup_pready_i;

    assign outstanding_o    = out_cnt_q;
    assign idle_o           = (out_cnt_q == '0);
    assign unexpected_rsp_o = unexpected_q;

    // Pack the incoming response.
    always_comb begin
        fifo_in       = '0;
        fifo_in.id    = fpu_pid_i;
        fifo_in.data  = fpu_pdata_i;
        fifo_in.error = fpu_perror_i;
    end

    // Scoreboard and credit counter next state; a pop and an issue of the same id cannot coincide.
    always_comb begin
        pend_d    = pend_q;
        out_cnt_d = out_cnt_q;
        if (pop) begin
            pend_d[fifo_out.id] = 1'b0;
        end
        if (track) begin
            pend_d[iss_qid_i] = 1'b1;
        end
        if (track && !pop) begin
            out_cnt_d = out_cnt_q + CntWidth'(1);
        end else if (pop && !track && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - CntWidth'(1);
        end
    end

    // Tracking state registers; the unexpected flag is sticky until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q       <= '0;
            out_cnt_q    <= '0;
            unexpected_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            out_cnt_q <= out_cnt_d;
            if (fpu_fire && !fpu_hit) begin
                unexpected_q <= 1'b1;
            end
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (Depth),
        .dtype        (rsp_t)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (fifo_in),
        .push_i  (push),
        .data_o  (fifo_out),
        .pop_i   (pop)
    );

endmodule

// File: doc/stitch_acc_responder.md
STITCH_ACC_RESPONDER -- requirements
Module: stitch_acc_responder

Interface
REQ-001 SHALL have parameter DataWidth, default 64: width of response data.
REQ-002 SHALL have parameter Depth, default 4: response FIFO entries and maximum outstanding responses; power of two, at least 2.
REQ-003 SHALL have port clk_i, input, 1: the single clock.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port iss_qid_i, input, 5: destination integer register id of the offloaded instruction.
REQ-006 SHALL have port iss_expect_rsp_i, input, 1: the instruction returns an integer result (float-to-int, CSR, imv.x).
REQ-007 SHALL have ports iss_qvalid_i (input, 1) and iss_qready_o (output, 1): upstream issue handshake.
REQ-008 SHALL have ports iss_qvalid_o (output, 1) and iss_qready_i (input, 1): downstream issue handshake toward the FPU subsystem.
REQ-009 SHALL have ports fpu_pid_i (input, 5), fpu_pdata_i (input, DataWidth) and fpu_perror_i (input, 1), with fpu_pvalid_i (input, 1) and fpu_pready_o (output, 1): FPU response.
REQ-010 SHALL have ports oup_pid_o (output, 5), oup_pdata_o (output, DataWidth) and oup_perror_o (output, 1), with oup_pvalid_o (output, 1) and oup_pready_i (input, 1): response to the integer core.
REQ-011 SHALL have port outstanding_o, output, $clog2(Depth+1): responses issued but not yet accepted by the core.
REQ-012 SHALL have port idle_o, output, 1: high when outstanding_o is 0.
REQ-013 SHALL have port unexpected_rsp_o, output, 1: sticky flag for an unmatched FPU response.

Function
REQ-014 SHALL hold a 32-bit pending scoreboard, one bit per qid.
- Bit is set on issue handshake with iss_expect_rsp_i=1.
- Bit is cleared on core output handshake for that id.
REQ-015 SHALL define a stall when iss_expect_rsp_i=1 and either the scoreboard bit for iss_qid_i is set (registered value, no bypass) or outstanding equals Depth.
REQ-016 SHALL drive iss_qvalid_o = iss_qvalid_i & ~stall and iss_qready_o = iss_qready_i & ~stall; the path is combinational with zero latency.
REQ-017 SHALL pass issues with iss_expect_rsp_i=0 untracked, gated only by iss_qready_i.
REQ-018 SHALL update the outstanding counter as +1 on tracked issue and -1 on core pop; both events in the same cycle leave it unchanged; it never exceeds Depth or underflows.
REQ-019 SHALL push {pid, pdata, perror} into the FIFO on FPU handshake only when the scoreboard bit for fpu_pid_i is set.
REQ-020 SHALL accept but discard an FPU response whose id is not pending, set unexpected_rsp_o on the next edge, and leave all other state unchanged.
REQ-021 SHALL drive fpu_pready_o = ~fifo_full; by REQ-015 the FIFO never overflows.
REQ-022 SHALL present a FIFO entry on oup_* one cycle after its FPU handshake (registered, no fall-through).
- Responses are delivered in arrival order.
- oup_* SHALL remain stable while oup_pvalid_o=1 and oup_pready_i=0.
REQ-023 SHALL allow a same-cycle pop of id X and issue of id X: the issue stalls that cycle and proceeds in the next cycle.
REQ-024 SHALL sustain one FPU push and one core pop per cycle when the FIFO holds 1..Depth-1 entries.

Reset
REQ-025 SHALL, while rst_ni=0, clear the scoreboard, outstanding counter, FIFO and unexpected_rsp_o.
REQ-026 SHALL drive these output values during reset: oup_pvalid_o=0, outstanding_o=0, idle_o=1, fpu_pready_o=1, unexpected_rsp_o=0.
REQ-027 SHALL discard all in-flight state on reset mid-operation; FPU responses arriving after reset for pre-reset issues SHALL set unexpected_rsp_o.

Structure
REQ-028 SHALL define the response entry struct {id[4:0], data, error} as acc_rsp_t, parameterised via type parameter, in stitch_pkg.
REQ-029 SHALL implement the FIFO by instantiating common_cells fifo_v3 with FALL_THROUGH=0; no other sub-module is used.

Verification
REQ-030 SHALL cover basic round trip: issue id 5 with expect=1, then FPU response id 5, data 0xDEAD -> oup_pvalid_o next cycle with id 5, data 0xDEAD; outstanding_o goes 1 then 0; idle_o=1 after pop.
REQ-031 SHALL cover the hazard: id 7 pending, issue id 7 -> iss_qready_o=0 until core pops id 7, then the issue completes in the following cycle.
REQ-032 SHALL cover credit limit: Depth=4, four tracked issues with ids 1-4 and no responses, fifth issue id 9 -> stalled; one response plus pop -> id 9 accepted; outstanding_o peaks at 4.
REQ-033 SHALL cover unexpected response: FPU response id 12 with nothing pending -> fpu_pready_o=1, no oup_pvalid_o, unexpected_rsp_o=1 and it stays 1.
REQ-034 SHALL cover backpressure: 4 responses with oup_pready_i=0 -> fpu_pready_o=0 and oup_* stable; release -> 4 pops in order on consecutive cycles.
REQ-035 SHALL cover reset mid-operation: 2 outstanding, assert rst_ni=0, release, then FPU response for an old id -> discarded, unexpected_rsp_o=1, outstanding_o=0.
